// File: rtl/la_hstx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : la_hstx_pkg
//  Purpose  : Shared state encodings for the la_hstx handshake source.
//  Revision : 1.0  initial release
// ============================================================================
package la_hstx_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 2'b00;
  localparam state_t ST_ASSERT  = 2'b01;
  localparam state_t ST_RELEASE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/la_dsync.sv
`default_nettype none
// ============================================================================
//  Module   : la_dsync
//  Purpose  : Multi-flop synchronizer for a single asynchronous bit.
//             Flops carry no reset so they can be packed as a sync cell.
//  Revision : 1.0  initial release
// ============================================================================
module la_dsync #(
  parameter        PROP   = "DEFAULT",
  parameter int    STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic dout
);

  // Non-default properties map onto the same portable flop chain here;
  // a technology library replaces this module with a hardened cell.
  if (PROP == "DEFAULT") begin : g_generic
    logic [STAGES-1:0] pipe;
    // Shift the asynchronous bit through the synchronizer chain
    always_ff @(posedge clk) begin
      pipe <= {pipe[STAGES-2:0], din};
    end
    assign dout = pipe[STAGES-1];
  end else begin : g_prop
    logic [STAGES-1:0] pipe;
    // Shift the asynchronous bit through the synchronizer chain
    always_ff @(posedge clk) begin
      pipe <= {pipe[STAGES-2:0], din};
    end
    assign dout = pipe[STAGES-1];
  end

endmodule
`default_nettype wire

// File: rtl/la_hstx.sv
`default_nettype none
// ============================================================================
//  Module   : la_hstx
//  Purpose  : Source half of a four-phase req/ack CDC handshake. Accepts a
//             word on valid/ready, holds it on xfer_data while sequencing
//             xfer_req, and tracks the synchronized acknowledge.
//  Revision : 1.0  initial release
// ============================================================================
module la_hstx
  import la_hstx_pkg::*;
#(
  parameter        PROP    = "DEFAULT",
  parameter int    DW      = 32,
  parameter int    STAGES  = 2,
  parameter int    TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          xfer_req,
  output logic [DW-1:0] xfer_data,
  input  logic          xfer_ack,
  output logic          busy,
  output logic          err,
  input  logic          err_clear
);

  // Counter is kept one bit wide when the timeout is disabled so it never
  // collapses to a zero-width vector.
  localparam int          CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic          ack_s;
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          timeout_hit;

  la_dsync #(
    .PROP   (PROP),
    .STAGES (STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .din  (xfer_ack),
    .dout (ack_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state decode; only the synchronized ack steers the FSM
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (accept)               state_next = ST_ASSERT;
      ST_ASSERT:  if (ack_s || timeout_hit) state_next = ST_RELEASE;
      ST_RELEASE: if (!ack_s)               state_next = ST_IDLE;
      default:                              state_next = ST_IDLE;
    endcase
  end

  // Output and strobe decode; a stale ack in IDLE blocks new words
  always_comb begin
    in_ready    = nreset && (state == ST_IDLE) && !ack_s;
    busy        = (state != ST_IDLE);
    accept      = in_valid && in_ready;
    timeout_hit = TO_EN && (state == ST_ASSERT) && !ack_s && (cnt == CNT_LAST);
  end

  // Datapath: req flop follows the next state so it is glitch-free,
  // data is captured only on accept, the counter saturates, err is sticky
  always_ff @(posedge clk) begin
    if (!nreset) begin
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      xfer_req <= (state_next == ST_ASSERT);
      if (accept) xfer_data <= in_data;
      if (accept)                                    cnt <= '0;
      else if (state == ST_ASSERT && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (timeout_hit)    err <= 1'b1;
      else if (err_clear) err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_la_hstx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_la_hstx
//  Purpose  : Self-checking bench for la_hstx. Instance A (TIMEOUT=0) runs
//             against a loopback / delayed / manual / random destination with
//             a scoreboard; instance B (TIMEOUT=8) covers abort behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_la_hstx;

  localparam int M_LOOP = 0;
  localparam int M_AUTO = 1;
  localparam int M_MAN  = 2;

  logic        clk = 1'b0;
  // instance A
  logic        a_nreset, a_valid, a_ready, a_req, a_ack, a_busy, a_err, a_clr;
  logic [31:0] a_in, a_xdata;
  // instance B
  logic        b_nreset, b_valid, b_ready, b_req, b_ack, b_busy, b_err, b_clr;
  logic [31:0] b_in, b_xdata;

  // destination model for A
  int          dmode = M_LOOP;
  logic        man_ack = 1'b0;
  logic        dack = 1'b0;
  int          dcnt = 0;
  int          fixed_lat = 0;
  int          rlat = 3;
  logic        drand = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          sent = 0;
  int          rx = 0;
  logic [31:0] exp_q[$];
  logic        req_prev = 1'b0;
  logic [31:0] held = '0;

  always #5 clk = ~clk;

  assign a_ack = (dmode == M_LOOP) ? a_req : (dmode == M_MAN) ? man_ack : dack;

  la_hstx #(.PROP("DEFAULT"), .DW(32), .STAGES(2), .TIMEOUT(0)) u_dut_a (
    .clk(clk), .nreset(a_nreset), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_in), .xfer_req(a_req), .xfer_data(a_xdata), .xfer_ack(a_ack),
    .busy(a_busy), .err(a_err), .err_clear(a_clr)
  );

  la_hstx #(.PROP("DEFAULT"), .DW(32), .STAGES(2), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .nreset(b_nreset), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_in), .xfer_req(b_req), .xfer_data(b_xdata), .xfer_ack(b_ack),
    .busy(b_busy), .err(b_err), .err_clear(b_clr)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Offer a word to A from a negedge; returns at the negedge after accept
  task automatic push_a(input logic [31:0] d);
    int w = 0;
    a_valid = 1'b1;
    a_in    = d;
    while (!a_ready && w < 200) begin @(negedge clk); w++; end
    if (!a_ready) begin
      fail_bound("push_a_ready");
      a_valid = 1'b0;
    end else begin
      exp_q.push_back(d);
      sent++;
      @(negedge clk);
      a_valid = 1'b0;
    end
  endtask

  task automatic push_b(input logic [31:0] d);
    int w = 0;
    b_valid = 1'b1;
    b_in    = d;
    while (!b_ready && w < 200) begin @(negedge clk); w++; end
    if (!b_ready) fail_bound("push_b_ready");
    else @(negedge clk);
    b_valid = 1'b0;
  endtask

  // Destination responder: mirror req onto ack after a latency
  always @(posedge clk) begin
    if (dmode == M_AUTO) begin
      if (dack == a_req) dcnt <= 0;
      else if (dcnt >= (drand ? rlat : fixed_lat)) begin
        dack <= a_req;
        dcnt <= 0;
        if (drand) rlat <= $urandom_range(0, 5);
      end else dcnt <= dcnt + 1;
    end
  end

  // Scoreboard monitor: pop on each new request, check data holds while high
  always @(negedge clk) begin
    if (a_req && !req_prev) begin
      rx++;
      if (exp_q.size() == 0) fail_bound("rx_unexpected_word");
      else chk32("rx_word", a_xdata, exp_q.pop_front());
      held = a_xdata;
    end else if (a_req && req_prev) begin
      chk32("data_stable", a_xdata, held);
    end
    req_prev = a_req;
  end

  // Watchdog
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed and random stimulus
  initial begin
    logic prev_dack;
    int   w;
    a_nreset = 1'b0; a_valid = 1'b0; a_in = '0; a_clr = 1'b0;
    b_nreset = 1'b0; b_valid = 1'b0; b_in = '0; b_clr = 1'b0; b_ack = 1'b0;

    // ---- reset state ----
    repeat (4) @(negedge clk);
    chk1("rst_ready_a", a_ready, 1'b0);
    chk1("rst_ready_b", b_ready, 1'b0);
    chk1("rst_req", a_req, 1'b0);
    chk32("rst_data", a_xdata, 32'h0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_err", a_err, 1'b0);
    a_nreset = 1'b1; b_nreset = 1'b1;
    @(negedge clk);
    chk1("post_rst_ready", a_ready, 1'b1);

    // ---- loopback, back to back ----
    for (int i = 1; i <= 2; i++) begin
      logic [31:0] d;
      d = 32'hA5A5_0000 + 32'(i);
      push_a(d);
      chk1("lb_req0", a_req, 1'b1);
      chk1("lb_busy0", a_busy, 1'b1);
      chk1("lb_ready0", a_ready, 1'b0);
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        chk1("lb_req", a_req, (k <= 2));
        chk1("lb_ready", a_ready, (k == 6));
      end
    end

    // ---- destination delays ack by 10 cycles, no timeout ----
    fixed_lat = 10; drand = 1'b0; dmode = M_AUTO;
    push_a(32'h0000_BEEF);
    prev_dack = dack;
    w = 0;
    while (!(prev_dack && !dack) && w < 100) begin
      prev_dack = dack;
      @(negedge clk);
      w++;
    end
    if (!(prev_dack && !dack)) fail_bound("delay_ack_fall");
    chk1("dly_busy0", a_busy, 1'b1);
    @(negedge clk); chk1("dly_busy1", a_busy, 1'b1);
    @(negedge clk); chk1("dly_busy2", a_busy, 1'b1);
    @(negedge clk); chk1("dly_busy3", a_busy, 1'b0);
    chk1("dly_ready3", a_ready, 1'b1);
    chk1("dly_err", a_err, 1'b0);

    // ---- timeout on B with ack tied low ----
    push_b(32'h0000_0011);
    chk1("to_req0", b_req, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk1("to_req", b_req, (k < 8));
      chk1("to_err", b_err, (k >= 8));
      chk1("to_busy", b_busy, (k <= 8));
      chk1("to_ready", b_ready, (k >= 9));
    end
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    chk1("err_cleared", b_err, 1'b0);
    // clear coinciding with a fresh timeout: set wins
    push_b(32'h0000_0022);
    repeat (7) @(negedge clk);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    chk1("set_wins_err", b_err, 1'b1);
    chk1("set_wins_req", b_req, 1'b0);
    @(negedge clk);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    chk1("err_cleared2", b_err, 1'b0);

    // ---- late ack after timeout on B ----
    push_b(32'h0000_0033);
    repeat (6) @(negedge clk);
    b_ack = 1'b1;
    b_valid = 1'b1; b_in = 32'h0000_0044;
    for (int k = 7; k <= 16; k++) begin
      @(negedge clk);
      if (k >= 8) begin
        chk1("late_req", b_req, 1'b0);
        chk1("late_err", b_err, 1'b1);
        chk1("late_busy", b_busy, (k <= 14));
        chk1("late_ready", b_ready, (k >= 15));
      end
      if (k == 12) b_ack = 1'b0;
      if (k == 14) b_valid = 1'b0;
    end
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;

    // ---- reset mid-ASSERT with ack high on A ----
    dmode = M_MAN; man_ack = 1'b0;
    push_a(32'h1234_5678);
    @(negedge clk); man_ack = 1'b1;
    @(negedge clk); a_nreset = 1'b0;
    @(negedge clk);
    chk1("mid_rst_req", a_req, 1'b0);
    chk1("mid_rst_busy", a_busy, 1'b0);
    chk1("mid_rst_err", a_err, 1'b0);
    chk32("mid_rst_data", a_xdata, 32'h0);
    chk1("mid_rst_ready", a_ready, 1'b0);
    @(negedge clk); a_nreset = 1'b1;
    for (int k = 5; k <= 9; k++) begin
      @(negedge clk);
      chk1("post_rst_gate", a_ready, (k == 9));
      if (k == 7) man_ack = 1'b0;
    end

    // ---- random valid against random-latency destination ----
    drand = 1'b1; dmode = M_AUTO;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] d;
      d = $urandom();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_a(d);
    end
    w = 0;
    while (a_busy && w < 300) begin @(negedge clk); w++; end
    if (a_busy) fail_bound("drain_busy");
    chk32("queue_empty", 32'(exp_q.size()), 32'h0);
    chk32("rx_count", 32'(rx), 32'(sent));
    chk1("final_err_a", a_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
